// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
// The optional transfer counter is enabled by defining RD_ADAPTER_XFER_CNT_EN.
package fifo_rd_stream_adapter_pkg;

  localparam int RD_LATENCY_MAX = 3;
  localparam int XFER_CNT_W     = 32;
  localparam int TAG_CNT_W      = $clog2(RD_LATENCY_MAX + 1);

  // One bit per pipeline stage between a pop request and its data landing.
  typedef logic [RD_LATENCY_MAX-1:0] inflight_tags_t;

  function automatic logic [TAG_CNT_W-1:0] tag_count(input inflight_tags_t tags);
    logic [TAG_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < RD_LATENCY_MAX; i++) begin
      cnt = cnt + TAG_CNT_W'(tags[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundle of the upstream FIFO pop port and the downstream valid/ready stream.
// Signal directions in the names are as seen from the adapter (master side).
interface fifo_rd_stream_adapter_if #(
  parameter int WIDTH = 8
);

  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_rd_en_o;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, ready_i,
    output fifo_rd_en_o, valid_o, data_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_rd_en_o, valid_o, data_o
  );

endinterface

// File: rtl/fifo_rd_stream_adapter_stream_flop_buf.sv
// Small flop-based FIFO that catches words landing from the upstream SRAM FIFO.
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
module fifo_rd_stream_adapter_stream_flop_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [OCC_W-1:0] occ_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q + OCC_W'(wr_en_i) - OCC_W'(rd_en_i);
    if (wr_en_i) tail_d = ptr_inc(tail_q);
    if (rd_en_i) head_d = ptr_inc(head_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[tail_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[head_q];
  assign occ_o     = occ_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the upstream FIFO pop port into a valid/ready stream using read credits.
// Define RD_ADAPTER_XFER_CNT_EN to add the 32-bit accepted-word counter xfer_cnt_o.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
`ifdef RD_ADAPTER_XFER_CNT_EN
  output logic [XFER_CNT_W-1:0]   xfer_cnt_o,
`endif
  fifo_rd_stream_adapter_if.master bus
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int W_OCC     = $clog2(BUF_DEPTH + 1);
  localparam int W_CRD     = W_OCC + 1;
  localparam inflight_tags_t TAG_MASK = inflight_tags_t'((1 << RD_LATENCY) - 1);

  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("RD_LATENCY must be in 1..%0d", RD_LATENCY_MAX);
  end

  inflight_tags_t   pipe_q, pipe_d;
  logic [W_OCC-1:0] occ;
  logic [W_CRD-1:0] credit_used;
  logic [WIDTH-1:0] head_data;
  logic             land, pop, rd_en, valid;

  assign land  = pipe_q[RD_LATENCY-1];
  assign valid = (occ != '0);
  assign pop   = valid & bus.ready_i;

  // A word popped this cycle frees its slot in time for a new request, which is
  // what lets the stream run at one word per cycle.
  always_comb begin
    credit_used = W_CRD'(occ) + W_CRD'(tag_count(pipe_q)) - W_CRD'(pop);
    rd_en       = rst_ni && !bus.fifo_empty_i && (credit_used < W_CRD'(BUF_DEPTH));
    pipe_d      = {pipe_q[RD_LATENCY_MAX-2:0], rd_en} & TAG_MASK;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pipe_q <= '0;
    else         pipe_q <= pipe_d;
  end

  fifo_rd_stream_adapter_stream_flop_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .OCC_W (W_OCC)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (land),
    .wr_data_i (bus.fifo_data_i),
    .rd_en_i   (pop),
    .rd_data_o (head_data),
    .occ_o     (occ)
  );

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.valid_o      = valid;
  assign bus.data_o       = valid ? head_data : '0;

`ifdef RD_ADAPTER_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  assign xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) xfer_cnt_q <= '0;
    else         xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt_o = xfer_cnt_q;
`endif

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(land && occ == W_OCC'(BUF_DEPTH) && !pop))
    else $error("word landed into a full buffer");

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: three DUTs (RD_LATENCY 1..3) vs a queue-based model.
// Upstream FIFO, landing data and stream buffer are modelled as plain queues.
module tb_fifo_rd_stream_adapter;
  import fifo_rd_stream_adapter_pkg::*;

  localparam int WIDTH = 8;
  localparam int NL    = 3;

  typedef struct {
    int               land_cyc;
    logic [WIDTH-1:0] d;
  } fly_t;

  logic clk_i;
  logic rst_ni;

  logic             empty_d [NL];
  logic [WIDTH-1:0] fdata_d [NL];
  logic             ready_d [NL];
  logic             rd_en_s [NL];
  logic             valid_s [NL];
  logic [WIDTH-1:0] data_s  [NL];
`ifdef RD_ADAPTER_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] cnt_s [NL];
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    fifo_rd_stream_adapter_if #(.WIDTH(WIDTH)) bus ();

    assign bus.fifo_empty_i = empty_d[g];
    assign bus.fifo_data_i  = fdata_d[g];
    assign bus.ready_i      = ready_d[g];
    assign rd_en_s[g]       = bus.fifo_rd_en_o;
    assign valid_s[g]       = bus.valid_o;
    assign data_s[g]        = bus.data_o;

    fifo_rd_stream_adapter #(
      .WIDTH      (WIDTH),
      .RD_LATENCY (g + 1)
    ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
`ifdef RD_ADAPTER_XFER_CNT_EN
      .xfer_cnt_o (cnt_s[g]),
`endif
      .bus        (bus)
    );
  end

  // Behavioural model state, one entry per lane
  logic [WIDTH-1:0] up_q [NL][$];
  fly_t             fly_q [NL][$];
  logic [WIDTH-1:0] sb_q [NL][$];
  int unsigned      acc_cnt [NL];
  int               cyc;

  int n_checks;
  int n_fail;

  // Observed-beat log used by the literal expectations
  int               beat_cnt   [NL];
  int               first_beat [NL];
  int               last_beat  [NL];
  int               first_rd   [NL];
  int               seq_err    [NL];
  logic [WIDTH-1:0] next_word  [NL];
  logic             last_rd    [NL];
  logic             last_valid [NL];
  logic [WIDTH-1:0] last_data  [NL];

  task automatic check(input string name, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d (RD_LATENCY=%0d) cyc %0d: got 0x%0h, expected 0x%0h",
               name, lane, lane + 1, cyc, act, exp);
    end
  endtask

  task automatic clear_log(input logic [WIDTH-1:0] base);
    for (int l = 0; l < NL; l++) begin
      beat_cnt[l]   = 0;
      first_beat[l] = -1;
      last_beat[l]  = -1;
      first_rd[l]   = -1;
      seq_err[l]    = 0;
      next_word[l]  = base;
    end
  endtask

  task automatic push_words(input logic [WIDTH-1:0] base, input int n);
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < n; i++) up_q[l].push_back(base + WIDTH'(i));
  endtask

  task automatic compare_lane(input int l);
    int               lat;
    int               bd;
    bit               exp_valid;
    bit               pop;
    bit               exp_rd;
    fly_t             f;
    logic [WIDTH-1:0] tmp;
    lat       = l + 1;
    bd        = l + 2;
    exp_valid = (sb_q[l].size() != 0);
    check("valid_o", l, 32'(valid_s[l]), 32'(exp_valid));
    if (exp_valid) check("data_o", l, 32'(data_s[l]), 32'(sb_q[l][0]));
    pop    = exp_valid && ready_d[l];
    exp_rd = !empty_d[l] && ((sb_q[l].size() + fly_q[l].size() - int'(pop)) < bd);
    check("fifo_rd_en_o", l, 32'(rd_en_s[l]), 32'(exp_rd));
`ifdef RD_ADAPTER_XFER_CNT_EN
    check("xfer_cnt_o", l, cnt_s[l], acc_cnt[l]);
`endif
    last_rd[l]    = rd_en_s[l];
    last_valid[l] = valid_s[l];
    last_data[l]  = data_s[l];
    if (rd_en_s[l] === 1'b1 && first_rd[l] < 0) first_rd[l] = cyc;
    if (valid_s[l] === 1'b1 && ready_d[l]) begin
      beat_cnt[l]++;
      if (first_beat[l] < 0) first_beat[l] = cyc;
      last_beat[l] = cyc;
      if (data_s[l] !== next_word[l]) seq_err[l]++;
      next_word[l] = next_word[l] + WIDTH'(1);
    end
    if (pop) begin
      tmp = sb_q[l].pop_front();
      acc_cnt[l]++;
    end
    if (fly_q[l].size() != 0 && fly_q[l][0].land_cyc == cyc) begin
      f = fly_q[l].pop_front();
      sb_q[l].push_back(f.d);
    end
    if (exp_rd) begin
      f.land_cyc = cyc + lat;
      f.d        = up_q[l].pop_front();
      fly_q[l].push_back(f);
    end
  endtask

  // One clock cycle: drive just after the rising edge, compare on the falling edge.
  task automatic step(input int ready_pct, input int gate_pct, input bit fill);
    for (int l = 0; l < NL; l++) begin
      if (fill && up_q[l].size() < 4 && $urandom_range(1) == 1)
        up_q[l].push_back(WIDTH'($urandom));
      empty_d[l] = (up_q[l].size() == 0) || ($urandom_range(99) < gate_pct);
      ready_d[l] = ($urandom_range(99) < ready_pct);
      if (fly_q[l].size() != 0 && fly_q[l][0].land_cyc == cyc) fdata_d[l] = fly_q[l][0].d;
      else                                                     fdata_d[l] = WIDTH'($urandom);
    end
    @(negedge clk_i);
    for (int l = 0; l < NL; l++) compare_lane(l);
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int cycles);
    rst_ni = 1'b0;
    for (int l = 0; l < NL; l++) begin
      empty_d[l] = 1'b0;
      ready_d[l] = 1'b1;
    end
    #1;
    for (int l = 0; l < NL; l++) begin
      check("rst fifo_rd_en_o", l, 32'(rd_en_s[l]), 32'd0);
      check("rst valid_o", l, 32'(valid_s[l]), 32'd0);
      check("rst data_o", l, 32'(data_s[l]), 32'd0);
`ifdef RD_ADAPTER_XFER_CNT_EN
      check("rst xfer_cnt_o", l, cnt_s[l], 32'd0);
`endif
      up_q[l].delete();
      fly_q[l].delete();
      sb_q[l].delete();
      acc_cnt[l] = 0;
    end
    repeat (cycles) @(posedge clk_i);
    #1;
    for (int l = 0; l < NL; l++) begin
      check("rst hold fifo_rd_en_o", l, 32'(rd_en_s[l]), 32'd0);
      check("rst hold valid_o", l, 32'(valid_s[l]), 32'd0);
    end
    rst_ni = 1'b1;
    cyc += cycles;
  endtask

  initial begin
    int start;
    logic [WIDTH-1:0] snap [NL];
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_ni   = 1'b1;
    for (int l = 0; l < NL; l++) begin
      empty_d[l] = 1'b1;
      ready_d[l] = 1'b0;
      fdata_d[l] = '0;
      acc_cnt[l] = 0;
    end
    clear_log('0);
    #2;
    do_reset(3);

    // Single word 0xA5: request in cycle 0, one beat in cycle RD_LATENCY+1
    clear_log(8'hA5);
    push_words(8'hA5, 1);
    start = cyc;
    repeat (8) step(100, 0, 0);
    for (int l = 0; l < NL; l++) begin
      check("single first rd_en cycle", l, 32'(first_rd[l] - start), 32'd0);
      check("single first beat cycle", l, 32'(first_beat[l] - start), 32'(l + 2));
      check("single beat count", l, 32'(beat_cnt[l]), 32'd1);
      check("single word order", l, 32'(seq_err[l]), 32'd0);
    end

    // Streaming 0..15 with ready held high: 16 back-to-back beats
    clear_log(8'h00);
    push_words(8'h00, 16);
    start = cyc;
    repeat (24) step(100, 0, 0);
    for (int l = 0; l < NL; l++) begin
      check("stream beat count", l, 32'(beat_cnt[l]), 32'd16);
      check("stream first beat cycle", l, 32'(first_beat[l] - start), 32'(l + 2));
      check("stream beats contiguous", l, 32'(last_beat[l] - first_beat[l]), 32'd15);
      check("stream word order", l, 32'(seq_err[l]), 32'd0);
    end

    // Backpressure: five cycles of ready low mid-stream
    clear_log(8'h20);
    push_words(8'h20, 16);
    repeat (6) step(100, 0, 0);
    step(0, 0, 0);
    for (int l = 0; l < NL; l++) snap[l] = last_data[l];
    repeat (4) step(0, 0, 0);
    for (int l = 0; l < NL; l++) begin
      check("stall requests stopped", l, 32'(last_rd[l]), 32'd0);
      check("stall valid held", l, 32'(last_valid[l]), 32'd1);
      check("stall data stable", l, 32'(last_data[l]), 32'(snap[l]));
    end
    repeat (24) step(100, 0, 0);
    for (int l = 0; l < NL; l++) begin
      check("backpressure beat count", l, 32'(beat_cnt[l]), 32'd16);
      check("backpressure word order", l, 32'(seq_err[l]), 32'd0);
    end

    // Random empty/ready against the model, then drain
    repeat (10000) step(70, 30, 1);
    repeat (12) step(100, 0, 0);

    // Reset with words in flight; only post-reset data may appear afterwards
    clear_log(8'h00);
    push_words(8'h10, 16);
    repeat (2) step(0, 0, 0);
    @(posedge clk_i);
    #1;
    do_reset(2);
    clear_log(8'h40);
    push_words(8'h40, 8);
    start = cyc;
    repeat (16) step(100, 0, 0);
    for (int l = 0; l < NL; l++) begin
      check("post-reset beat count", l, 32'(beat_cnt[l]), 32'd8);
      check("post-reset first beat cycle", l, 32'(first_beat[l] - start), 32'(l + 2));
      check("post-reset word order", l, 32'(seq_err[l]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
